// File: rtl/text_cursor_ctrl.sv
// text_cursor_ctrl: owns every write into the text-mode character buffer.
// It blanks the whole buffer after reset and turns keyboard events into
// single-port buffer writes. It also tracks the cursor and the scroll
// position. The scroll position is exported as roll_cnt, the start address
// of the first visible line.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   INIT    | blanking the whole buffer, one address per cycle
//   IDLE    | key_ready high, keyboard events are handled here
//   WRITE   | printable character write in flight
//   BKSP    | blank written at the cursor after a backspace move
//   NEWLINE | carriage return / line feed, may scroll the screen
//   CLEAR   | blanking the freshly exposed bottom line after a scroll
module text_cursor_ctrl #(
  parameter int COLS      = 70,
  parameter int ROWS      = 30,
  parameter int BUF_LINES = 64
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        key_valid,
  output logic        key_ready,
  input  logic [7:0]  key_ascii,
  input  logic        key_dir,
  input  logic [7:0]  key_code,
  output logic        wr_en,
  output logic [12:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic [6:0]  cursor_x,
  output logic [4:0]  cursor_y,
  output logic [12:0] roll_cnt
);

  localparam int          LW       = $clog2(BUF_LINES);
  localparam logic [12:0] TOTAL    = 13'(BUF_LINES * COLS);
  localparam logic [12:0] CLR_LAST = 13'(COLS - 1);
  localparam logic [6:0]  LAST_COL = 7'(COLS - 1);
  localparam logic [4:0]  LAST_ROW = 5'(ROWS - 1);
  localparam logic [LW:0] NLINES   = BUF_LINES[LW:0];
  localparam logic [LW:0] LINE_M1  = NLINES - 1;
  localparam logic [LW:0] LINE_P1  = 1;

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_WRITE, S_BKSP, S_NEWLINE, S_CLEAR
  } state_t;

  state_t          r_state;
  logic [12:0]     r_cnt;
  logic [6:0]      r_cx;
  logic [4:0]      r_cy;
  logic [LW-1:0]   r_top;
  logic [12:0]     r_roll;
  logic            r_wr_en;
  logic [12:0]     r_wr_addr;
  logic [7:0]      r_wr_data;
  logic            r_key_ready;

  logic [LW-1:0]   w_cur_line;
  logic [LW-1:0]   w_prev_line;
  logic [LW-1:0]   w_next_line;
  logic [LW-1:0]   w_top_next;
  logic [12:0]     w_cur_addr;
  logic            w_printable;

  // Buffer line to its first address.
  function automatic logic [12:0] line_base(input logic [LW-1:0] line);
    return 13'(line) * 13'(COLS);
  endfunction

  // Line arithmetic modulo BUF_LINES; b is always below BUF_LINES.
  function automatic logic [LW-1:0] line_add(input logic [LW-1:0] a, input logic [LW:0] b);
    logic [LW:0] s;
    s = {1'b0, a} + b;
    if (s >= NLINES) s = s - NLINES;
    return s[LW-1:0];
  endfunction

  assign w_cur_line  = line_add(r_top, (LW+1)'(r_cy));
  assign w_prev_line = line_add(w_cur_line, LINE_M1);
  assign w_next_line = line_add(w_cur_line, LINE_P1);
  assign w_top_next  = line_add(r_top, LINE_P1);
  assign w_cur_addr  = line_base(w_cur_line) + 13'(r_cx);
  assign w_printable = (key_ascii >= 8'h20) && (key_ascii <= 8'h7E);

  // Controller FSM: cursor, scroll and write-port registers all update here.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      r_state     <= S_INIT;
      r_cnt       <= '0;
      r_cx        <= '0;
      r_cy        <= '0;
      r_top       <= '0;
      r_roll      <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_key_ready <= 1'b0;
    end else begin
      case (r_state)
        S_INIT: begin
          if (r_cnt < TOTAL) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_cnt;
            r_wr_data <= 8'h20;
            r_cnt     <= r_cnt + 13'd1;
          end else begin
            r_wr_en     <= 1'b0;
            r_key_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (key_valid) begin
            if (key_dir) begin
              // Direction keys never write or scroll and finish in this cycle.
              case (key_code)
                8'h75:   if (r_cy != 5'd0)     r_cy <= r_cy - 5'd1;
                8'h72:   if (r_cy != LAST_ROW) r_cy <= r_cy + 5'd1;
                8'h6B:   if (r_cx != 7'd0)     r_cx <= r_cx - 7'd1;
                8'h74:   if (r_cx != LAST_COL) r_cx <= r_cx + 7'd1;
                default: ;
              endcase
            end else if (w_printable) begin
              r_wr_en     <= 1'b1;
              r_wr_addr   <= w_cur_addr;
              r_wr_data   <= key_ascii;
              r_key_ready <= 1'b0;
              r_state     <= S_WRITE;
            end else if (key_ascii == 8'h0D || key_ascii == 8'h0A) begin
              r_key_ready <= 1'b0;
              r_state     <= S_NEWLINE;
            end else if (key_ascii == 8'h08) begin
              // Backspace at the home position is consumed without effect.
              if (r_cx != 7'd0) begin
                r_cx        <= r_cx - 7'd1;
                r_wr_en     <= 1'b1;
                r_wr_addr   <= w_cur_addr - 13'd1;
                r_wr_data   <= 8'h20;
                r_key_ready <= 1'b0;
                r_state     <= S_BKSP;
              end else if (r_cy != 5'd0) begin
                r_cy        <= r_cy - 5'd1;
                r_cx        <= LAST_COL;
                r_wr_en     <= 1'b1;
                r_wr_addr   <= line_base(w_prev_line) + 13'(LAST_COL);
                r_wr_data   <= 8'h20;
                r_key_ready <= 1'b0;
                r_state     <= S_BKSP;
              end
            end
          end
        end
        S_WRITE: begin
          r_wr_en <= 1'b0;
          if (r_cx == LAST_COL) begin
            r_state <= S_NEWLINE;
          end else begin
            r_cx        <= r_cx + 7'd1;
            r_key_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        S_BKSP: begin
          r_wr_en     <= 1'b0;
          r_key_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
        S_NEWLINE: begin
          r_cx <= '0;
          if (r_cy != LAST_ROW) begin
            r_cy        <= r_cy + 5'd1;
            r_key_ready <= 1'b1;
            r_state     <= S_IDLE;
          end else begin
            // Scroll: the line after the current bottom becomes visible and
            // its first blank goes out in the same edge.
            r_top     <= w_top_next;
            r_roll    <= line_base(w_top_next);
            r_wr_en   <= 1'b1;
            r_wr_addr <= line_base(w_next_line);
            r_wr_data <= 8'h20;
            r_cnt     <= '0;
            r_state   <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          if (r_cnt == CLR_LAST) begin
            r_wr_en     <= 1'b0;
            r_key_ready <= 1'b1;
            r_state     <= S_IDLE;
          end else begin
            r_cnt     <= r_cnt + 13'd1;
            r_wr_addr <= r_wr_addr + 13'd1;
          end
        end
        default: begin
          r_state     <= S_INIT;
          r_cnt       <= '0;
          r_wr_en     <= 1'b0;
          r_key_ready <= 1'b0;
        end
      endcase
    end
  end

  assign key_ready = r_key_ready;
  assign wr_en     = r_wr_en;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign cursor_x  = r_cx;
  assign cursor_y  = r_cy;
  assign roll_cnt  = r_roll;

endmodule
